// File: rtl/sps_pkg.sv
// Shared encodings for the stone/paper/scissors game: moves, winner codes,
// FSM states, and the move-ordering rule used by the judge.
package sps_pkg;

  typedef enum logic [1:0] {
    MOVE_STONE    = 2'b00,
    MOVE_PAPER    = 2'b01,
    MOVE_SCISSORS = 2'b10,
    MOVE_INVALID  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    WIN_TIE     = 2'b00,
    WIN_P1      = 2'b01,
    WIN_P2      = 2'b10,
    WIN_INVALID = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  // True when move a defeats move b; both are assumed valid.
  function automatic logic beats(input move_t a, input move_t b);
    return (a == MOVE_STONE    && b == MOVE_SCISSORS) ||
           (a == MOVE_SCISSORS && b == MOVE_PAPER)    ||
           (a == MOVE_PAPER    && b == MOVE_STONE);
  endfunction

endpackage

// File: rtl/sps_judge.sv
// Purely combinational referee: two 2-bit moves in, 2-bit winner code out.
module sps_judge
  import sps_pkg::*;
(
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  output logic [1:0] winner
);

  move_t   m1, m2;
  winner_t w;

  always_comb begin
    m1 = move_t'(p1_move);
    m2 = move_t'(p2_move);
    w  = WIN_P2;
    if (m1 == MOVE_INVALID || m2 == MOVE_INVALID) w = WIN_INVALID;
    else if (m1 == m2)                            w = WIN_TIE;
    else if (beats(m1, m2))                       w = WIN_P1;
  end

  assign winner = w;

endmodule

// File: rtl/tt_um_stone_paper_scissors.sv
// Stone/paper/scissors round controller with round counter; per-player
// scores exist only when the SPS_SCORE_EN macro is defined.
module tt_um_stone_paper_scissors
  import sps_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     state, state_nxt;
  logic       start_q, start_edge, round_start, score_clr;
  logic [1:0] p1_q, p2_q, judge_winner, winner_q;
  logic [3:0] round_q;

  // Despite its name, rst_n resets when high, synchronously.
  assign start_edge  = ui_in[4] & ~start_q;
  assign round_start = (state == ST_IDLE) && ena && start_edge;
  assign score_clr   = ui_in[5];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_n) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      ST_IDLE: if (round_start) state_nxt = ST_EVAL;
      ST_EVAL: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  sps_judge u_judge (
    .p1_move (p1_q),
    .p2_move (p2_q),
    .winner  (judge_winner)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      start_q  <= 1'b0;
      p1_q     <= 2'b00;
      p2_q     <= 2'b00;
      winner_q <= 2'b00;
      round_q  <= 4'd0;
    end else begin
      start_q <= ui_in[4];
      if (round_start) begin
        p1_q <= ui_in[1:0];
        p2_q <= ui_in[3:2];
      end
      if (state == ST_EVAL) winner_q <= judge_winner;
      // Clear beats a round completing on the same edge.
      if (score_clr)              round_q <= 4'd0;
      else if (state == ST_EVAL)  round_q <= round_q + 4'd1;
    end
  end

  assign uo_out = {round_q, (state != ST_IDLE), (state == ST_DONE), winner_q};

`ifdef SPS_SCORE_EN
  logic [3:0] p1_score, p2_score;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      p1_score <= 4'd0;
      p2_score <= 4'd0;
    end else if (score_clr) begin
      p1_score <= 4'd0;
      p2_score <= 4'd0;
    end else if (state == ST_EVAL) begin
      if (judge_winner == WIN_P1 && p1_score != SCORE_MAX) p1_score <= p1_score + 4'd1;
      if (judge_winner == WIN_P2 && p2_score != SCORE_MAX) p2_score <= p2_score + 4'd1;
    end
  end

  assign uio_out = {p2_score, p1_score};
  assign uio_oe  = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

  logic unused_inputs;
  assign unused_inputs = &{1'b0, uio_in, ui_in[7:6]};

endmodule

// File: tb/tb_tt_um_stone_paper_scissors.sv
// Directed self-checking bench for tt_um_stone_paper_scissors; score checks
// follow the SPS_SCORE_EN build setting.
module tb_tt_um_stone_paper_scissors;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int fails  = 0;

  tt_um_stone_paper_scissors dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_uio(input int s1, input int s2);
`ifdef SPS_SCORE_EN
    return {4'(s2), 4'(s1)};
`else
    return 8'h00;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full round: start edge, EVAL, DONE, back to IDLE.
  task automatic play(input logic [1:0] p1, input logic [1:0] p2,
                      output logic [7:0] uo_eval, output logic [7:0] uo_done,
                      output logic [7:0] uio_done, output logic [7:0] uo_after);
    ui_in = {4'b0001, p2, p1};
    step();
    uo_eval = uo_out;
    ui_in[4] = 1'b0;
    step();
    uo_done  = uo_out;
    uio_done = uio_out;
    step();
    uo_after = uo_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (3) step();
    checks++;
    if (uo_out !== 8'h00) begin fails++; $display("FAIL reset_uo: got %h want 00", uo_out); end
    checks++;
    if (uio_out !== exp_uio(0, 0)) begin fails++; $display("FAIL reset_uio: got %h want %h", uio_out, exp_uio(0, 0)); end
    rst_n = 1'b0;
    step();
    checks++;
    if (uo_out !== 8'h00) begin fails++; $display("FAIL idle_after_reset: got %h want 00", uo_out); end
  endtask

  task automatic test_first_round();
    logic [7:0] e, d, u, a;
    play(2'b00, 2'b10, e, d, u, a);
    checks++;
    if (e !== 8'h08) begin fails++; $display("FAIL first_eval: got %h want 08", e); end
    checks++;
    if (d !== 8'h1D) begin fails++; $display("FAIL first_done: got %h want 1d", d); end
    checks++;
    if (u !== exp_uio(1, 0)) begin fails++; $display("FAIL first_score: got %h want %h", u, exp_uio(1, 0)); end
    checks++;
    if (a !== 8'h11) begin fails++; $display("FAIL first_after: got %h want 11", a); end
  endtask

  task automatic test_sequence();
    logic [1:0] m1 [5] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [1:0] m2 [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [1:0] w  [5] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b11};
    logic [7:0] e, d, u, a, want;
    int s1 = 1, s2 = 0;
    for (int i = 0; i < 5; i++) begin
      play(m1[i], m2[i], e, d, u, a);
      if (w[i] == 2'b01) s1++;
      if (w[i] == 2'b10) s2++;
      want = {4'(i + 2), 2'b11, w[i]};
      checks++;
      if (d !== want) begin fails++; $display("FAIL seq_done[%0d]: got %h want %h", i, d, want); end
      want = {4'(i + 2), 2'b00, w[i]};
      checks++;
      if (a !== want) begin fails++; $display("FAIL seq_after[%0d]: got %h want %h", i, a, want); end
    end
    checks++;
    if (uio_out !== exp_uio(3, 1)) begin fails++; $display("FAIL seq_scores: got %h want %h", uio_out, exp_uio(3, 1)); end
    checks++;
    if (s1 != 3 || s2 != 1) begin fails++; $display("FAIL seq_table: got %0d/%0d want 3/1", s1, s2); end
  endtask

  task automatic test_start_held();
    int pulses = 0;
    ui_in = 8'b0001_1000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (uo_out[2]) pulses++;
      if (i == 4) ui_in[4] = 1'b0;
    end
    checks++;
    if (pulses != 1) begin fails++; $display("FAIL held_pulses: got %0d want 1", pulses); end
    checks++;
    if (uo_out !== 8'h71) begin fails++; $display("FAIL held_uo: got %h want 71", uo_out); end
    checks++;
    if (uio_out !== exp_uio(4, 1)) begin fails++; $display("FAIL held_scores: got %h want %h", uio_out, exp_uio(4, 1)); end
  endtask

  task automatic test_ignore_busy();
    int pulses = 0;
    ui_in = 8'b0001_1000;
    step();
    ui_in[4] = 1'b0;
    step();
    if (uo_out[2]) pulses++;
    ui_in[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (uo_out[2]) pulses++;
    end
    ui_in = 8'h00;
    step();
    checks++;
    if (pulses != 1) begin fails++; $display("FAIL busy_edge_pulses: got %0d want 1", pulses); end
    checks++;
    if (uo_out !== 8'h81) begin fails++; $display("FAIL busy_edge_uo: got %h want 81", uo_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, d, u, a;
    ui_in = 8'h20;
    step();
    ui_in = 8'h00;
    checks++;
    if (uo_out !== 8'h01) begin fails++; $display("FAIL clear_idle: got %h want 01", uo_out); end
    for (int i = 0; i < 16; i++) begin
      play(2'b01, 2'b00, e, d, u, a);
      if (i == 14) begin
        checks++;
        if (u !== exp_uio(15, 0) || a !== 8'hF1) begin
          fails++; $display("FAIL sat_15: got %h/%h want %h/f1", u, a, exp_uio(15, 0));
        end
      end
    end
    checks++;
    if (u !== exp_uio(15, 0)) begin fails++; $display("FAIL sat_hold: got %h want %h", u, exp_uio(15, 0)); end
    checks++;
    if (a !== 8'h01) begin fails++; $display("FAIL round_wrap: got %h want 01", a); end
  endtask

  task automatic test_clear();
    ui_in = 8'b0001_1000;
    step();
    ui_in[4] = 1'b0;
    step();
    checks++;
    if (uo_out !== 8'h1D) begin fails++; $display("FAIL clr_pre_done: got %h want 1d", uo_out); end
    ui_in[5] = 1'b1;
    step();
    ui_in = 8'h00;
    checks++;
    if (uo_out !== 8'h01 || uio_out !== exp_uio(0, 0)) begin
      fails++; $display("FAIL clr_in_done: got %h/%h want 01/%h", uo_out, uio_out, exp_uio(0, 0));
    end
    ui_in = 8'b0001_1001;
    step();
    ui_in = 8'b0010_1001;
    step();
    checks++;
    if (uo_out !== 8'h0E || uio_out !== exp_uio(0, 0)) begin
      fails++; $display("FAIL clr_vs_done: got %h/%h want 0e/%h", uo_out, uio_out, exp_uio(0, 0));
    end
    ui_in = 8'h00;
    step();
    checks++;
    if (uo_out !== 8'h02) begin fails++; $display("FAIL clr_after: got %h want 02", uo_out); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, d, u, a;
    int pulses = 0;
    play(2'b01, 2'b00, e, d, u, a);
    checks++;
    if (a !== 8'h11 || u !== exp_uio(1, 0)) begin
      fails++; $display("FAIL pre_reset_round: got %h/%h want 11/%h", a, u, exp_uio(1, 0));
    end
    ui_in = 8'b0001_0100;
    step();
    checks++;
    if (uo_out !== 8'h19) begin fails++; $display("FAIL mid_eval: got %h want 19", uo_out); end
    rst_n = 1'b1;
    ui_in = 8'h00;
    step();
    checks++;
    if (uo_out !== 8'h00 || uio_out !== exp_uio(0, 0)) begin
      fails++; $display("FAIL mid_reset: got %h/%h want 00/%h", uo_out, uio_out, exp_uio(0, 0));
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (uo_out[2]) pulses++;
    end
    checks++;
    if (pulses != 0 || uo_out !== 8'h00) begin
      fails++; $display("FAIL mid_abandon: got pulses %0d uo %h want 0/00", pulses, uo_out);
    end
  endtask

  task automatic test_ena();
    int busy_seen = 0;
    ena   = 1'b0;
    ui_in = 8'b0001_1000;
    for (int i = 0; i < 4; i++) begin
      step();
      if (uo_out[3]) busy_seen++;
    end
    ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (uo_out[3]) busy_seen++;
    end
    ui_in = 8'h00;
    step();
    checks++;
    if (busy_seen != 0) begin fails++; $display("FAIL ena_busy: got %0d busy cycles want 0", busy_seen); end
    checks++;
    if (uo_out !== 8'h00) begin fails++; $display("FAIL ena_uo: got %h want 00", uo_out); end
  endtask

  task automatic test_config();
    logic [7:0] want;
`ifdef SPS_SCORE_EN
    want = 8'hFF;
`else
    want = 8'h00;
`endif
    checks++;
    if (uio_oe !== want) begin fails++; $display("FAIL uio_oe: got %h want %h", uio_oe, want); end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_sequence();
    test_start_held();
    test_ignore_busy();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_ena();
    test_config();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
